// File: rtl/masked_serial_adder_ctrl.sv
// Bit-serial first-order Boolean-masked W-bit adder sequencer.
// Two masked half-adder gadgets per cycle; carry shares registered between bit steps.
module masked_serial_adder_ctrl #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b0,
  input  logic [W-1:0] b1,
  input  logic [1:0]   rnd,
  input  logic         rnd_valid,
  output logic         rnd_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] s0,
  output logic [W-1:0] s1,
  output logic         c0,
  output logic         c1,
  output logic         busy
);

  localparam int unsigned IW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a0_q, a1_q, b0_q, b1_q;
  logic [W-1:0]    s0_q, s1_q;
  logic            cy0_q, cy1_q;
  logic            c0_q, c1_q;
  logic [IW-1:0]   idx_q;

  logic accept, step, last;
  logic x0, x1, y0, y1;
  logic h1s0, h1s1, h1c0, h1c1;
  logic h2s0, h2s1, h2c0, h2c1;
  logic nc0, nc1;

  assign in_ready  = (state_q == IDLE);
  assign rnd_ready = (state_q == RUN);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign s0 = s0_q;
  assign s1 = s1_q;
  assign c0 = c0_q;
  assign c1 = c1_q;

  assign accept = in_valid && in_ready;
  assign step   = (state_q == RUN) && rnd_valid;
  assign last   = (idx_q == IW'(W - 1));

  assign x0 = a0_q[idx_q];
  assign x1 = a1_q[idx_q];
  assign y0 = b0_q[idx_q];
  assign y1 = b1_q[idx_q];

  // Cross-share products are folded onto the fresh mask before touching the other share.
  assign h1s0 = x0 ^ y0;
  assign h1s1 = x1 ^ y1;
  assign h1c0 = (x0 & y0) ^ rnd[0];
  assign h1c1 = (x1 & y1) ^ ((rnd[0] ^ (x0 & y1)) ^ (x1 & y0));

  assign h2s0 = h1s0 ^ cy0_q;
  assign h2s1 = h1s1 ^ cy1_q;
  assign h2c0 = (h1s0 & cy0_q) ^ rnd[1];
  assign h2c1 = (h1s1 & cy1_q) ^ ((rnd[1] ^ (h1s0 & cy1_q)) ^ (h1s1 & cy0_q));

  assign nc0 = h1c0 ^ h2c0;
  assign nc1 = h1c1 ^ h2c1;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (step && last) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a0_q  <= '0;
      a1_q  <= '0;
      b0_q  <= '0;
      b1_q  <= '0;
      s0_q  <= '0;
      s1_q  <= '0;
      cy0_q <= 1'b0;
      cy1_q <= 1'b0;
      c0_q  <= 1'b0;
      c1_q  <= 1'b0;
      idx_q <= '0;
    end else if (accept) begin
      a0_q  <= a0;
      a1_q  <= a1;
      b0_q  <= b0;
      b1_q  <= b1;
      cy0_q <= 1'b0;
      cy1_q <= 1'b0;
      idx_q <= '0;
    end else if (step) begin
      s0_q[idx_q] <= h2s0;
      s1_q[idx_q] <= h2s1;
      cy0_q       <= nc0;
      cy1_q       <= nc1;
      if (last) begin
        c0_q  <= nc0;
        c1_q  <= nc1;
        idx_q <= '0;
      end else begin
        idx_q <= idx_q + IW'(1);
      end
    end
  end

endmodule

// File: tb/tb_masked_serial_adder_ctrl.sv
// Bench for masked_serial_adder_ctrl (W=4): behavioural model plus directed literal cases.
module tb_masked_serial_adder_ctrl;
  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready;
  logic [W-1:0] a0, a1, b0, b1;
  logic [1:0]   rnd;
  logic         rnd_valid, rnd_ready;
  logic         out_valid, out_ready;
  logic [W-1:0] s0, s1;
  logic         c0, c1, busy;

  masked_serial_adder_ctrl #(.W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a0(a0), .a1(a1), .b0(b0), .b1(b1), .rnd(rnd), .rnd_valid(rnd_valid),
    .rnd_ready(rnd_ready), .out_valid(out_valid), .out_ready(out_ready),
    .s0(s0), .s1(s1), .c0(c0), .c1(c1), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Model: 0 idle, 1 running, 2 done; bits_left counts remaining bit steps.
  int           m_state;
  int           m_left;
  logic [W-1:0] m_sum;
  logic         m_carry;
  bit           m_clean;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state = 0;
      m_left  = 0;
      m_sum   = '0;
      m_carry = 1'b0;
      m_clean = 1'b1;
    end else begin
      case (m_state)
        0: if (in_valid) begin
          logic [W:0] tot;
          tot     = {1'b0, a0 ^ a1} + {1'b0, b0 ^ b1};
          m_sum   = tot[W-1:0];
          m_carry = tot[W];
          m_left  = W;
          m_state = 1;
          m_clean = 1'b0;
        end
        1: if (rnd_valid) begin
          m_left--;
          if (m_left == 0) m_state = 2;
        end
        default: if (out_ready) m_state = 0;
      endcase
    end
  end

  int hs = 0;
  always @(posedge clk) if (!rst && rnd_ready && rnd_valid) hs++;

  bit           prev_done = 1'b0;
  logic [W-1:0] p_s0, p_s1;
  logic         p_c0, p_c1;

  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready",  in_ready,  m_state == 0);
      chk("busy",      busy,      m_state != 0);
      chk("rnd_ready", rnd_ready, m_state == 1);
      chk("out_valid", out_valid, m_state == 2);
      if (m_state == 2) begin
        chk("sum",   s0 ^ s1, m_sum);
        chk("carry", c0 ^ c1, m_carry);
        if (prev_done) begin
          chk("hold_s0", s0, p_s0);
          chk("hold_s1", s1, p_s1);
          chk("hold_c",  {c0, c1}, {p_c0, p_c1});
        end
      end
      if (m_clean) chk("reset_outs", {s0, s1, c0, c1}, '0);
      prev_done = (m_state == 2);
      p_s0 = s0; p_s1 = s1; p_c0 = c0; p_c1 = c1;
    end else begin
      prev_done = 1'b0;
    end
  end

  // mode: 0 rnd always valid, 1 first three RUN cycles stalled, 2 random stalls
  task automatic run_op(input logic [W-1:0] ia0, ia1, ib0, ib1, input int mode,
                        input int hold, input bit poke,
                        output int lat, output logic [W-1:0] rs, output logic rc);
    int stalls;
    stalls = 0;
    @(negedge clk);
    in_valid = 1'b1; a0 = ia0; a1 = ia1; b0 = ib0; b1 = ib1;
    rnd_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a0 = $urandom; a1 = $urandom; b0 = $urandom; b1 = $urandom;
    lat = 0;
    while (!out_valid && lat < 100) begin
      case (mode)
        0: rnd_valid = 1'b1;
        1: begin rnd_valid = (stalls >= 3); if (!rnd_valid) stalls++; end
        default: rnd_valid = ($urandom_range(0, 3) != 0);
      endcase
      rnd = 2'($urandom_range(0, 3));
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    rnd_valid = 1'b0;
    chk("op_done", out_valid, 1'b1);
    rs = s0 ^ s1;
    rc = c0 ^ c1;
    for (int i = 0; i < hold; i++) begin
      in_valid = poke;
      @(posedge clk);
      @(negedge clk);
      chk("busy_no_accept", in_ready, 1'b0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_hs_valid", out_valid, 1'b0);
    chk("post_hs_ready", in_ready, 1'b1);
  endtask

  initial begin
    int           lat;
    logic [W-1:0] rs;
    logic         rc;
    logic [W-1:0] m, n;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; rnd_valid = 1'b0; rnd = '0;
    a0 = '0; a1 = '0; b0 = '0; b1 = '0;
    #12;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_rnd_ready", rnd_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_outs", {s0, s1, c0, c1}, '0);
    @(negedge clk);
    rst = 1'b0;

    // A=5, B=3
    hs = 0;
    run_op(4'hA, 4'hF, 4'h6, 4'h5, 0, 0, 1'b0, lat, rs, rc);
    chk("t1_lat", lat, 4);
    chk("t1_sum", rs, 4'h8);
    chk("t1_carry", rc, 1'b0);
    chk("t1_hs", hs, 4);

    // A=F, B=1 with random masks: full carry ripple
    m = 4'($urandom); n = 4'($urandom);
    run_op(m, m ^ 4'hF, n, n ^ 4'h1, 0, 0, 1'b0, lat, rs, rc);
    chk("t2_sum", rs, 4'h0);
    chk("t2_carry", rc, 1'b1);

    // same operands, three stalls, then output backpressure with a poke
    hs = 0;
    run_op(m, m ^ 4'hF, n, n ^ 4'h1, 1, 5, 1'b1, lat, rs, rc);
    chk("t3_lat", lat, 7);
    chk("t3_sum", rs, 4'h0);
    chk("t3_carry", rc, 1'b1);
    chk("t3_rnd_bits", 2 * hs, 8);

    // reset after two bit steps
    @(negedge clk);
    in_valid = 1'b1; a0 = 4'h3; a1 = 4'h9; b0 = 4'h1; b1 = 4'h7;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; rnd_valid = 1'b1; rnd = 2'b10;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rnd_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_outs", {s0, s1, c0, c1}, '0);
    chk("mid_rst_in_ready", in_ready, 1'b1);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_out_valid", out_valid, 1'b0);
    @(negedge clk);
    #2 rst = 1'b0;

    run_op(4'h7, 4'h5, 4'h3, 4'h1, 0, 0, 1'b0, lat, rs, rc);
    chk("t4_sum", rs, 4'h4);
    chk("t4_carry", rc, 1'b0);

    for (int k = 0; k < 1000; k++) begin
      logic [W-1:0] ra, rb, ma, mb;
      logic [W:0]   tot;
      ra = 4'($urandom); rb = 4'($urandom); ma = 4'($urandom); mb = 4'($urandom);
      tot = {1'b0, ra} + {1'b0, rb};
      run_op(ma, ma ^ ra, mb, mb ^ rb, 2, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
             lat, rs, rc);
      chk("rand_sum", rs, tot[W-1:0]);
      chk("rand_carry", rc, tot[W]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
